// File: rtl/mem_resp_pkg.sv
// Shared types and size encodings for the memory responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU memory port (master) and the responder (slave).
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for loads/stores on a 32-bit little-endian word.
// MEM_RESP_ALIGN_CHECK_EN: flag misaligned half/word accesses instead of truncating the address.
module mem_lane_align
    import mem_resp_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [1:0] lane;
    logic [4:0] bsh;

    always_comb begin
        misalign_o = 1'b0;
`ifdef MEM_RESP_ALIGN_CHECK_EN
        case (size_i)
            SIZE_BYTE: misalign_o = 1'b0;
            SIZE_HALF: misalign_o = lane_i[0];
            default:   misalign_o = |lane_i;
        endcase
`endif
        // Datapath always uses the naturally aligned lane; a flagged access discards it.
        case (size_i)
            SIZE_BYTE: lane = lane_i;
            SIZE_HALF: lane = {lane_i[1], 1'b0};
            default:   lane = 2'b00;
        endcase
        bsh     = {lane, 3'b000};
        wword_o = rword_i;
        rdata_o = '0;
        case (size_i)
            SIZE_BYTE: begin
                wword_o[bsh +: 8] = wdata_i[7:0];
                rdata_o[7:0]      = rword_i[bsh +: 8];
            end
            SIZE_HALF: begin
                wword_o[bsh +: 16] = wdata_i[15:0];
                rdata_o[15:0]      = rword_i[bsh +: 16];
            end
            default: begin
                wword_o = wdata_i;
                rdata_o = rword_i;
            end
        endcase
        if (misalign_o) rdata_o = '0;
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable wait states and a one-cycle response pulse.
// Optional MEM_RESP_ALIGN_CHECK_EN (handled in mem_lane_align) reports misaligned accesses via rsp_error.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    mem_responder_if.slave bus
);

    localparam int         AW       = ADDR_W + 2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_error_q, rsp_error_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          access;
    logic          acc_write;
    logic [1:0]    acc_size;
    logic [AW-1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic [31:0]   rword, wword, rdata;
    logic          misalign;
    logic          unused_addr_hi;

    logic [31:0] mem_q [2**ADDR_W];

    // Address bits above the array depth alias onto the same words.
    assign unused_addr_hi = ^bus.req_addr[31:AW];

    // With zero wait states the access happens on the accept edge, straight from the bus.
    always_comb begin
        if (state_q == IDLE) begin
            acc_write = bus.req_write;
            acc_size  = bus.req_size;
            acc_addr  = bus.req_addr[AW-1:0];
            acc_wdata = bus.req_wdata;
        end else begin
            acc_write = write_q;
            acc_size  = size_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    assign rword = mem_q[acc_addr[AW-1:2]];

    mem_lane_align u_align (
        .lane_i     (acc_addr[1:0]),
        .size_i     (acc_size),
        .wdata_i    (acc_wdata),
        .rword_i    (rword),
        .wword_o    (wword),
        .rdata_o    (rdata),
        .misalign_o (misalign)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    size_d  = bus.req_size;
                    addr_d  = bus.req_addr[AW-1:0];
                    wdata_d = bus.req_wdata;
                    if (WAIT_CYCLES != 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                        access  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d     = (state_d == IDLE);
        rsp_valid_d = access;
        rsp_error_d = access & misalign;
        rsp_rdata_d = (access && !acc_write && !misalign) ? rdata : 32'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_ff @(posedge clock) begin
        write_q <= write_d;
        size_q  <= size_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // A store caught by reset on its access edge is dropped.
    always_ff @(posedge clock) begin
        if (!reset && access && acc_write && !misalign)
            mem_q[acc_addr[AW-1:2]] <= wword;
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: byte-array reference model, in-order expected-response queue.
module tb_mem_responder;
    import mem_resp_pkg::*;

    localparam int ADDR_W      = 8;
    localparam int WAIT_CYCLES = 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_responder_if bus();

    mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   acc_q[$];
    int   n_chk = 0, n_pass = 0;
    int   cyc = 0, acc_total = 0, rsp_cnt = 0, n_pushed = 0;
    logic [7:0] ref_b [1024];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    endtask

    // Reference: memory as 1024 bytes (256 words), address wraps at 1 KiB.
    task automatic model(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int nb, base;
        bit mis;
        nb   = (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
        base = int'(a & 32'h3FF);
        mis  = 1'b0;
`ifdef MEM_RESP_ALIGN_CHECK_EN
        mis = (base % nb) != 0;
`else
        base = base - (base % nb);
`endif
        rd = 32'd0;
        er = mis;
        if (mis) return;
        for (int i = 0; i < nb; i++) begin
            if (wr) ref_b[base + i] = wd[8*i +: 8];
            else    rd[8*i +: 8]    = ref_b[base + i];
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.req_ready && n < 64) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) check_eq({tag, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input bit hold,
                          input bit use_exp = 1'b0, input logic [31:0] exp_d = 32'd0,
                          input logic exp_e = 1'b0);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        model(wr, sz, a, wd, e.rdata, e.err);
        e.tag = tag;
        if (use_exp) begin
            e.rdata = exp_d;
            e.err   = exp_e;
        end
        wait_ready(tag);
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        sb_q.push_back(e);
        n_pushed++;
        @(posedge clock);
        @(negedge clock);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        #1;
        check_eq({tag, "_drained"}, sb_q.size(), 32'd0);
    endtask

    always @(posedge clock) begin
        cyc++;
        if (reset) acc_q.delete();
        else if (bus.req_valid && bus.req_ready) begin
            acc_q.push_back(cyc);
            acc_total++;
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (bus.rsp_valid) begin
                rsp_cnt++;
                check_eq("ready_in_resp", bus.req_ready, 32'd0);
                if (sb_q.size() == 0) check_eq("unexpected_rsp", 32'd1, 32'd0);
                else begin
                    e = sb_q.pop_front();
                    check_eq({e.tag, "_rdata"}, bus.rsp_rdata, e.rdata);
                    check_eq({e.tag, "_err"}, bus.rsp_error, e.err);
                end
                if (acc_q.size() != 0) check_eq("latency", cyc - acc_q.pop_front(), WAIT_CYCLES);
                else check_eq("latency_no_accept", 32'd1, 32'd0);
            end else begin
                check_eq("rdata_idle", bus.rsp_rdata, 32'd0);
                check_eq("err_idle", bus.rsp_error, 32'd0);
            end
        end
    end

    initial begin
        int a0, r0;
        logic [31:0] ra;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size  = SIZE_WORD;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;

        repeat (3) @(negedge clock);
        check_eq("rst_ready", bus.req_ready, 32'd0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 32'd0);
        check_eq("rst_rdata", bus.rsp_rdata, 32'd0);
        check_eq("rst_err", bus.rsp_error, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check_eq("ready_after_rst", bus.req_ready, 32'd1);

        do_req("st_w10", 1'b1, SIZE_WORD, 32'h10, 32'hDEADBEEF, 1'b0);
        do_req("ld_w10", 1'b0, SIZE_WORD, 32'h10, 32'd0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);

        do_req("st_b11", 1'b1, SIZE_BYTE, 32'h11, 32'h000000AA, 1'b0);
        do_req("ld_w10b", 1'b0, SIZE_WORD, 32'h10, 32'd0, 1'b0, 1'b1, 32'hDEADAAEF, 1'b0);
        do_req("ld_b13", 1'b0, SIZE_BYTE, 32'h13, 32'd0, 1'b0, 1'b1, 32'h000000DE, 1'b0);
        do_req("ld_h12", 1'b0, SIZE_HALF, 32'h12, 32'd0, 1'b0, 1'b1, 32'h0000DEAD, 1'b0);

`ifdef MEM_RESP_ALIGN_CHECK_EN
        do_req("ld_h11_mis", 1'b0, SIZE_HALF, 32'h11, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1);
        do_req("st_h11_mis", 1'b1, SIZE_HALF, 32'h11, 32'h0000BEEF, 1'b0, 1'b1, 32'd0, 1'b1);
        do_req("ld_w13_mis", 1'b0, SIZE_WORD, 32'h13, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1);
        do_req("ld_w10_keep", 1'b0, SIZE_WORD, 32'h10, 32'd0, 1'b0, 1'b1, 32'hDEADAAEF, 1'b0);
`else
        do_req("ld_h11_trunc", 1'b0, SIZE_HALF, 32'h11, 32'd0, 1'b0, 1'b1, 32'h0000AAEF, 1'b0);
        do_req("ld_w13_trunc", 1'b0, SIZE_WORD, 32'h13, 32'd0, 1'b0, 1'b1, 32'hDEADAAEF, 1'b0);
`endif

        do_req("st_w400", 1'b1, SIZE_WORD, 32'h400, 32'h12345678, 1'b0);
        do_req("ld_w000", 1'b0, SIZE_WORD, 32'h000, 32'd0, 1'b0, 1'b1, 32'h12345678, 1'b0);

        // Back-to-back with req_valid never dropping between requests.
        drain("pre_burst");
        a0 = acc_total;
        r0 = rsp_cnt;
        for (int i = 0; i < 6; i++)
            do_req("burst", (i % 2) == 0, SIZE_WORD, 32'h30 + 32'(4 * (i / 2)),
                   $urandom, i != 5);
        drain("burst");
        check_eq("burst_accepts", acc_total - a0, 32'd6);
        check_eq("burst_one_rsp_each", rsp_cnt - r0, acc_total - a0);

        // Store interrupted by reset while waiting must never land.
        do_req("st_zero20", 1'b1, SIZE_WORD, 32'h20, 32'd0, 1'b0);
        wait_ready("rst_mid");
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = SIZE_WORD;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h55;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check_eq("rst_mid_ready", bus.req_ready, 32'd0);
        check_eq("rst_mid_rsp", bus.rsp_valid, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst_mid_ready_back", bus.req_ready, 32'd1);
        do_req("ld_w20_after_rst", 1'b0, SIZE_WORD, 32'h20, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0);

        for (int w = 0; w < 16; w++)
            do_req("rnd_init", 1'b1, SIZE_WORD, 32'h40 + 32'(4 * w), $urandom, 1'b0);
        for (int k = 0; k < 40; k++) begin
            ra = 32'h40 + 32'($urandom_range(0, 63));
            do_req("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom,
                   1'($urandom_range(0, 1)));
        end
        bus.req_valid = 1'b0;

        drain("final");
        check_eq("rsp_count", rsp_cnt, n_pushed);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
